pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB). Every cycle it computes the enable and flush controls for the PC and the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It handles:
- load-use hazards,
- taken branches and jumps,
- data-memory wait states,
- a halt/drain sequence that ends the SAD program cleanly.

It also keeps saturating stall and flush counters for performance reporting.

## Interface
Parameters:
- LOAD_BUBBLES, default 1: bubbles inserted per load-use hazard; legal values 1 or 2 (2 when MEM/WB to EX forwarding is disabled).
- CNT_W, default 16: width of the performance counters.

Ports:
- clk  in  1  clock; everything is on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- id_rs, id_rt  in  5 each  source registers of the instruction in ID.
- id_uses_rt  in  1  the ID instruction reads rt as a source.
- ex_mem_read  in  1  the instruction in EX is a load.
- ex_write_reg  in  5  destination register of the EX instruction.
- mem_mem_read  in  1  the instruction in MEM is a load.
- mem_write_reg  in  5  destination register of the MEM instruction.
- jump_id  in  1  a jump is decoded in ID.
- branch_taken_ex  in  1  a branch resolved taken in EX.
- mem_busy  in  1  data memory has not completed the access.
- halt_req  in  1  halt instruction decoded in ID; pulse or level.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register load enables.
- if_id_flush, id_ex_flush  out  1 each  load a NOP/bubble (all control fields zero) instead of the incoming data.
- mem_wb_bubble  out  1  the MEM/WB register captures RegWrite=0 and MemToReg=0.
- halted  out  1  pipeline drained and frozen.
- stall_cycles, flush_events  out  CNT_W each  saturating counters.

## Operation
The FSM state is registered. Outputs are combinational from the state and the current inputs.

FSM states: RUN, LD_STALL, MEM_WAIT, DRAIN, HALTED.

Hazard detection:
- load-use hazard (lu) = ex_mem_read && ex_write_reg≠0 && (ex_write_reg==id_rs || (id_uses_rt && ex_write_reg==id_rt)).
- When LOAD_BUBBLES=2, lu also fires for mem_mem_read/mem_write_reg under the same rule, but only in RUN.

Priority within RUN, evaluated every cycle:
1. mem_busy: freeze every stage, set mem_wb_bubble, go to MEM_WAIT.
2. branch_taken_ex: if_id_flush=1, id_ex_flush=1, all enables=1, flush_events+1. Any lu or jump_id in the same cycle is ignored, because those instructions are on the wrong path.
3. lu: pc_en=0, if_id_en=0, id_ex_flush=1, later stages enabled, stall_cycles+1. If LOAD_BUBBLES=2 and the producer is in EX, go to LD_STALL with a remaining-bubble count of 1; otherwise stay in RUN.
4. jump_id: if_id_flush=1, all enables=1, flush_events+1.
5. halt_req: same outputs as jump_id, which kills the fall-through fetch. Then pc_en is held at 0 and the FSM goes to DRAIN with drain_cnt=3.
6. Otherwise all enables=1 and all flushes=0.

LD_STALL:
- Repeats the lu outputs and decrements the bubble count; returns to RUN when it reaches 0.
- mem_busy pre-empts it: go to MEM_WAIT. The bubble count is kept and re-evaluated through lu on exit.

MEM_WAIT:
- All enables=0 and mem_wb_bubble=1, so WB commits nothing twice. stall_cycles+1 per cycle.
- Exits to RUN the first cycle mem_busy=0, and that cycle's outputs follow the RUN rules.
- Inputs are frozen while waiting, so a pending branch, lu or halt is re-seen on exit and not lost.

DRAIN:
- pc_en=0, if_id_flush=1, all other enables=1. drain_cnt decrements each cycle.
- At 0 the FSM goes to HALTED.
- mem_busy freezes DRAIN exactly as it does in RUN, without decrementing.
- A branch_taken_ex during DRAIN is ignored, because halt is architecturally final.

HALTED:
- All enables=0, mem_wb_bubble=1, halted=1.
- Only Reset leaves this state.

Counters:
- Both counters saturate at 2^CNT_W−1 and never wrap.
- Both are frozen in HALTED.

## Timing
- Reset (synchronous, takes effect on the next clk edge): state=RUN, counters=0, bubble and drain counts=0.
  - While Reset=1 the outputs are forced: all enables=1, all flushes=0, mem_wb_bubble=0, halted=0.
  - Reset wins over every other input in the same cycle, including mid-DRAIN and mid-MEM_WAIT.
- Load-use: zero-latency detection. With LOAD_BUBBLES=1, exactly 1 bubble; the dependent instruction is in EX 2 cycles after first being seen in ID.
- Branch: the flush is asserted in the same cycle that branch_taken_ex=1. The target is fetched on the next edge.
- Counters update on the edge that ends the counted cycle.
- halted rises exactly 4 cycles after the halt_req edge, provided there are no mem_busy cycles; each mem_busy cycle adds one.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - the state enum,
  - the DRAIN_DEPTH=4 constant,
  - the NOP/bubble encoding shared with the pipeline registers.
- Natural sub-module: sat_counter (CNT_W, inc, clr), instantiated twice.

## Test plan
- Load lw $8 in EX, add with rs=$8 in ID, LOAD_BUBBLES=1 -> one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; stall_cycles=1.
- Same stimulus with LOAD_BUBBLES=2 -> two stall cycles; the state visits LD_STALL once; stall_cycles=2. ex_write_reg=0 -> no stall.
- branch_taken_ex=1 together with lu=1 and jump_id=1 -> only the branch flush (if_id_flush=id_ex_flush=1); flush_events=1; no stall counted.
- mem_busy high for 3 cycles during a pending branch -> 3 frozen cycles with mem_wb_bubble=1, then the flush in cycle 4; stall_cycles=3, flush_events=1.
- halt_req pulse -> halted=1 after 4 cycles. Adding a 2-cycle mem_busy inside DRAIN -> halted=1 after 6 cycles. Reset in HALTED -> RUN with counters=0 on the next edge.
- Force 2^CNT_W+5 stall cycles (CNT_W=4) -> stall_cycles holds at 15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller and the pipeline
// registers it steers: FSM states, drain depth and the NOP control encoding.
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        LD_STALL = 3'd1,
        MEM_WAIT = 3'd2,
        DRAIN    = 3'd3,
        HALTED   = 3'd4
    } ctrl_state_t;

    // Cycles from the halt decode until the pipeline is frozen, halt cycle included.
    localparam int DRAIN_DEPTH = 4;
    localparam int DRAIN_CNT_W = 2;
    localparam int BUBBLE_CNT_W = 2;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       alu_src;
        logic [1:0] alu_op;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_NOP = '0;

    function automatic logic load_use(input logic       producerIsLoad,
                                      input logic [4:0] producerReg,
                                      input logic [4:0] rs,
                                      input logic [4:0] rt,
                                      input logic       usesRt);
        return producerIsLoad && (producerReg != 5'd0) &&
               ((producerReg == rs) || (usesRt && (producerReg == rt)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch/jump
// flushes, data-memory wait states and the halt drain, plus performance counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LOAD_BUBBLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_write_reg,
    input  logic             mem_mem_read,
    input  logic [4:0]       mem_write_reg,
    input  logic             jump_id,
    input  logic             branch_taken_ex,
    input  logic             mem_busy,
    input  logic             halt_req,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    ctrl_state_t             state_q, state_d;
    logic [BUBBLE_CNT_W-1:0] bubbleCnt_q, bubbleCnt_d;
    logic [DRAIN_CNT_W-1:0]  drainCnt_q, drainCnt_d;

    logic luEx;
    logic luMem;
    logic luAny;
    logic runRules;
    logic stallInc;
    logic flushInc;

    assign luEx  = load_use(ex_mem_read, ex_write_reg, id_rs, id_rt, id_uses_rt);
    assign luMem = load_use(mem_mem_read, mem_write_reg, id_rs, id_rt, id_uses_rt);
    assign luAny = luEx || ((LOAD_BUBBLES == 2) && luMem);

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q     <= RUN;
            bubbleCnt_q <= '0;
            drainCnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            bubbleCnt_q <= bubbleCnt_d;
            drainCnt_q  <= drainCnt_d;
        end
    end

    // MEM_WAIT hands its first non-busy cycle to the RUN priority chain, so
    // whatever was pending when memory stalled is acted on without loss.
    always_comb begin
        state_d       = state_q;
        bubbleCnt_d   = bubbleCnt_q;
        drainCnt_d    = drainCnt_q;
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        ex_mem_en     = 1'b1;
        mem_wb_en     = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b0;
        halted        = 1'b0;
        stallInc      = 1'b0;
        flushInc      = 1'b0;
        runRules      = 1'b0;

        unique case (state_q)
            RUN: runRules = 1'b1;
            LD_STALL: begin
                if (mem_busy) begin
                    {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
                    mem_wb_bubble = 1'b1;
                    stallInc      = 1'b1;
                    state_d       = MEM_WAIT;
                end else begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                    stallInc    = 1'b1;
                    bubbleCnt_d = bubbleCnt_q - 1'b1;
                    if (bubbleCnt_q <= 2'd1) begin
                        state_d = RUN;
                    end
                end
            end
            MEM_WAIT: begin
                if (mem_busy) begin
                    {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
                    mem_wb_bubble = 1'b1;
                    stallInc      = 1'b1;
                end else begin
                    runRules = 1'b1;
                end
            end
            DRAIN: begin
                if (mem_busy) begin
                    {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
                    mem_wb_bubble = 1'b1;
                    stallInc      = 1'b1;
                end else begin
                    pc_en       = 1'b0;
                    if_id_flush = 1'b1;
                    drainCnt_d  = drainCnt_q - 1'b1;
                    if (drainCnt_q <= 2'd1) begin
                        state_d = HALTED;
                    end
                end
            end
            HALTED: begin
                {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
                mem_wb_bubble = 1'b1;
                halted        = 1'b1;
            end
            default: state_d = RUN;
        endcase

        if (runRules) begin
            state_d = RUN;
            if (mem_busy) begin
                {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
                mem_wb_bubble = 1'b1;
                stallInc      = 1'b1;
                state_d       = MEM_WAIT;
            end else if (branch_taken_ex) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                flushInc    = 1'b1;
            end else if (luAny) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
                stallInc    = 1'b1;
                if ((LOAD_BUBBLES == 2) && luEx) begin
                    bubbleCnt_d = 2'd1;
                    state_d     = LD_STALL;
                end
            end else if (jump_id) begin
                if_id_flush = 1'b1;
                flushInc    = 1'b1;
            end else if (halt_req) begin
                if_id_flush = 1'b1;
                flushInc    = 1'b1;
                drainCnt_d  = DRAIN_CNT_W'(DRAIN_DEPTH - 1);
                state_d     = DRAIN;
            end
        end

        if (Reset) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '1;
            if_id_flush   = 1'b0;
            id_ex_flush   = 1'b0;
            mem_wb_bubble = 1'b0;
            halted        = 1'b0;
            stallInc      = 1'b0;
            flushInc      = 1'b0;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i   (clk),
        .clr_i   (Reset),
        .inc_i   (stallInc),
        .count_o (stall_cycles)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk_i   (clk),
        .clr_i   (Reset),
        .inc_i   (flushInc),
        .count_o (flush_events)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: two controllers (1 bubble / 4-bit counters and
// 2 bubbles / 16-bit counters) share stimulus; expected outputs go through a scoreboard queue.
module tb_pipeline_hazard_ctrl;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       usesRt;
        logic       exRd;
        logic [4:0] exWr;
        logic       memRd;
        logic [4:0] memWr;
        logic       jump;
        logic       br;
        logic       busy;
        logic       halt;
    } stim_t;

    typedef struct packed {
        logic [8:0]  ctl1;
        logic [15:0] st1;
        logic [15:0] fl1;
        logic [8:0]  ctl2;
        logic [15:0] st2;
        logic [15:0] fl2;
    } exp_t;

    // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, mem_wb_bubble, halted}
    localparam logic [8:0] NORM = 9'b111110000;
    localparam logic [8:0] LU   = 9'b001110100;
    localparam logic [8:0] BR   = 9'b111111100;
    localparam logic [8:0] JMP  = 9'b111111000;
    localparam logic [8:0] FRZ  = 9'b000000010;
    localparam logic [8:0] DRN  = 9'b011111000;
    localparam logic [8:0] HLT  = 9'b000000011;

    logic       clk;
    logic       Reset;
    logic [4:0] id_rs, id_rt, ex_write_reg, mem_write_reg;
    logic       id_uses_rt, ex_mem_read, mem_mem_read;
    logic       jump_id, branch_taken_ex, mem_busy, halt_req;

    logic        pcEn1, ifIdEn1, idExEn1, exMemEn1, memWbEn1, ifIdFl1, idExFl1, bub1, halted1;
    logic        pcEn2, ifIdEn2, idExEn2, exMemEn2, memWbEn2, ifIdFl2, idExFl2, bub2, halted2;
    logic [3:0]  stall1, flush1;
    logic [15:0] stall2, flush2;
    logic [40:0] obs1, obs2;

    int   errors;
    int   checks;
    exp_t sb[$];

    assign obs1 = {pcEn1, ifIdEn1, idExEn1, exMemEn1, memWbEn1, ifIdFl1, idExFl1, bub1, halted1,
                   12'd0, stall1, 12'd0, flush1};
    assign obs2 = {pcEn2, ifIdEn2, idExEn2, exMemEn2, memWbEn2, ifIdFl2, idExFl2, bub2, halted2,
                   stall2, flush2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.LOAD_BUBBLES(1), .CNT_W(4)) u_dut1 (
        .clk(clk), .Reset(Reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_write_reg(ex_write_reg),
        .mem_mem_read(mem_mem_read), .mem_write_reg(mem_write_reg),
        .jump_id(jump_id), .branch_taken_ex(branch_taken_ex), .mem_busy(mem_busy),
        .halt_req(halt_req), .pc_en(pcEn1), .if_id_en(ifIdEn1), .id_ex_en(idExEn1),
        .ex_mem_en(exMemEn1), .mem_wb_en(memWbEn1), .if_id_flush(ifIdFl1),
        .id_ex_flush(idExFl1), .mem_wb_bubble(bub1), .halted(halted1),
        .stall_cycles(stall1), .flush_events(flush1)
    );

    pipeline_hazard_ctrl #(.LOAD_BUBBLES(2), .CNT_W(16)) u_dut2 (
        .clk(clk), .Reset(Reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_write_reg(ex_write_reg),
        .mem_mem_read(mem_mem_read), .mem_write_reg(mem_write_reg),
        .jump_id(jump_id), .branch_taken_ex(branch_taken_ex), .mem_busy(mem_busy),
        .halt_req(halt_req), .pc_en(pcEn2), .if_id_en(ifIdEn2), .id_ex_en(idExEn2),
        .ex_mem_en(exMemEn2), .mem_wb_en(memWbEn2), .if_id_flush(ifIdFl2),
        .id_ex_flush(idExFl2), .mem_wb_bubble(bub2), .halted(halted2),
        .stall_cycles(stall2), .flush_events(flush2)
    );

    function automatic exp_t mkx(input logic [8:0] c1, input int s1, input int f1,
                                 input logic [8:0] c2, input int s2, input int f2);
        exp_t r;
        r.ctl1 = c1;
        r.st1  = 16'(s1);
        r.fl1  = 16'(f1);
        r.ctl2 = c2;
        r.st2  = 16'(s2);
        r.fl2  = 16'(f2);
        return r;
    endfunction

    function automatic stim_t stLuEx(input logic [4:0] r);
        stim_t s = '0;
        s.exRd = 1'b1;
        s.exWr = r;
        s.rs   = r;
        return s;
    endfunction

    task automatic applyStimulus(input stim_t s);
        Reset           = s.rst;
        id_rs           = s.rs;
        id_rt           = s.rt;
        id_uses_rt      = s.usesRt;
        ex_mem_read     = s.exRd;
        ex_write_reg    = s.exWr;
        mem_mem_read    = s.memRd;
        mem_write_reg   = s.memWr;
        jump_id         = s.jump;
        branch_taken_ex = s.br;
        mem_busy        = s.busy;
        halt_req        = s.halt;
    endtask

    task automatic applyReset();
        stim_t s = '0;
        s.rst = 1'b1;
        @(negedge clk);
        applyStimulus(s);
    endtask

    task automatic test_reset();
        stim_t sq[$];
        exp_t  xq[$];
        stim_t s;
        exp_t  x;
        applyReset();
        s = stLuEx(5'd3); s.rst = 1'b1; s.busy = 1'b1; s.br = 1'b1;
        sq.push_back(s);  xq.push_back(mkx(NORM, 0, 0, NORM, 0, 0));
        s = '0;           sq.push_back(s); xq.push_back(mkx(NORM, 0, 0, NORM, 0, 0));
        s = '0; s.busy = 1'b1;
        sq.push_back(s);  xq.push_back(mkx(FRZ, 0, 0, FRZ, 0, 0));
        s.rst = 1'b1;     sq.push_back(s); xq.push_back(mkx(NORM, 1, 0, NORM, 1, 0));
        s.rst = 1'b0;     sq.push_back(s); xq.push_back(mkx(FRZ, 0, 0, FRZ, 0, 0));
        s = '0;           sq.push_back(s); xq.push_back(mkx(NORM, 1, 0, NORM, 1, 0));
        for (int i = 0; i < sq.size(); i++) begin
            @(negedge clk);
            applyStimulus(sq[i]);
            sb.push_back(xq[i]);
            #1;
            x = sb.pop_front();
            checks++;
            if (obs1 !== {x.ctl1, x.st1, x.fl1}) begin
                errors++;
                $display("[TB] FAIL reset[%0d] dut1 got=%h expected=%h", i, obs1, {x.ctl1, x.st1, x.fl1});
            end
            checks++;
            if (obs2 !== {x.ctl2, x.st2, x.fl2}) begin
                errors++;
                $display("[TB] FAIL reset[%0d] dut2 got=%h expected=%h", i, obs2, {x.ctl2, x.st2, x.fl2});
            end
        end
    endtask

    task automatic test_load_use();
        stim_t sq[$];
        exp_t  xq[$];
        stim_t s;
        exp_t  x;
        applyReset();
        sq.push_back(stLuEx(5'd8)); xq.push_back(mkx(LU, 0, 0, LU, 0, 0));
        s = '0; s.memRd = 1'b1; s.memWr = 5'd8; s.rs = 5'd8;
        sq.push_back(s);  xq.push_back(mkx(NORM, 1, 0, LU, 1, 0));
        s = '0;           sq.push_back(s); xq.push_back(mkx(NORM, 1, 0, NORM, 2, 0));
        sq.push_back(stLuEx(5'd0)); xq.push_back(mkx(NORM, 1, 0, NORM, 2, 0));
        s = '0; s.exRd = 1'b1; s.exWr = 5'd9; s.rt = 5'd9; s.rs = 5'd1;
        sq.push_back(s);  xq.push_back(mkx(NORM, 1, 0, NORM, 2, 0));
        s.usesRt = 1'b1;  sq.push_back(s); xq.push_back(mkx(LU, 1, 0, LU, 2, 0));
        s = '0;           sq.push_back(s); xq.push_back(mkx(NORM, 2, 0, LU, 3, 0));
        sq.push_back(s);  xq.push_back(mkx(NORM, 2, 0, NORM, 4, 0));
        s = '0; s.memRd = 1'b1; s.memWr = 5'd5; s.rs = 5'd5;
        sq.push_back(s);  xq.push_back(mkx(NORM, 2, 0, LU, 4, 0));
        s = '0;           sq.push_back(s); xq.push_back(mkx(NORM, 2, 0, NORM, 5, 0));
        for (int i = 0; i < sq.size(); i++) begin
            @(negedge clk);
            applyStimulus(sq[i]);
            sb.push_back(xq[i]);
            #1;
            x = sb.pop_front();
            checks++;
            if (obs1 !== {x.ctl1, x.st1, x.fl1}) begin
                errors++;
                $display("[TB] FAIL loaduse[%0d] dut1 got=%h expected=%h", i, obs1, {x.ctl1, x.st1, x.fl1});
            end
            checks++;
            if (obs2 !== {x.ctl2, x.st2, x.fl2}) begin
                errors++;
                $display("[TB] FAIL loaduse[%0d] dut2 got=%h expected=%h", i, obs2, {x.ctl2, x.st2, x.fl2});
            end
        end
    endtask

    task automatic test_branch_priority();
        stim_t sq[$];
        exp_t  xq[$];
        stim_t s;
        exp_t  x;
        applyReset();
        s = stLuEx(5'd8); s.br = 1'b1; s.jump = 1'b1;
        sq.push_back(s);  xq.push_back(mkx(BR, 0, 0, BR, 0, 0));
        s = '0;           sq.push_back(s); xq.push_back(mkx(NORM, 0, 1, NORM, 0, 1));
        s.jump = 1'b1;    sq.push_back(s); xq.push_back(mkx(JMP, 0, 1, JMP, 0, 1));
        s = '0;           sq.push_back(s); xq.push_back(mkx(NORM, 0, 2, NORM, 0, 2));
        s = stLuEx(5'd4); s.jump = 1'b1;
        sq.push_back(s);  xq.push_back(mkx(LU, 0, 2, LU, 0, 2));
        s = '0;           sq.push_back(s); xq.push_back(mkx(NORM, 1, 2, LU, 1, 2));
        sq.push_back(s);  xq.push_back(mkx(NORM, 1, 2, NORM, 2, 2));
        for (int i = 0; i < sq.size(); i++) begin
            @(negedge clk);
            applyStimulus(sq[i]);
            sb.push_back(xq[i]);
            #1;
            x = sb.pop_front();
            checks++;
            if (obs1 !== {x.ctl1, x.st1, x.fl1}) begin
                errors++;
                $display("[TB] FAIL branch[%0d] dut1 got=%h expected=%h", i, obs1, {x.ctl1, x.st1, x.fl1});
            end
            checks++;
            if (obs2 !== {x.ctl2, x.st2, x.fl2}) begin
                errors++;
                $display("[TB] FAIL branch[%0d] dut2 got=%h expected=%h", i, obs2, {x.ctl2, x.st2, x.fl2});
            end
        end
    endtask

    task automatic test_mem_wait();
        stim_t sq[$];
        exp_t  xq[$];
        stim_t s;
        exp_t  x;
        applyReset();
        s = '0; s.br = 1'b1; s.busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sq.push_back(s); xq.push_back(mkx(FRZ, k, 0, FRZ, k, 0));
        end
        s.busy = 1'b0;    sq.push_back(s); xq.push_back(mkx(BR, 3, 0, BR, 3, 0));
        s = '0;           sq.push_back(s); xq.push_back(mkx(NORM, 3, 1, NORM, 3, 1));
        s = stLuEx(5'd7); sq.push_back(s); xq.push_back(mkx(LU, 3, 1, LU, 3, 1));
        s.busy = 1'b1;    sq.push_back(s); xq.push_back(mkx(FRZ, 4, 1, FRZ, 4, 1));
        s.busy = 1'b0;    sq.push_back(s); xq.push_back(mkx(LU, 5, 1, LU, 5, 1));
        s = '0;           sq.push_back(s); xq.push_back(mkx(NORM, 6, 1, LU, 6, 1));
        sq.push_back(s);  xq.push_back(mkx(NORM, 6, 1, NORM, 7, 1));
        for (int i = 0; i < sq.size(); i++) begin
            @(negedge clk);
            applyStimulus(sq[i]);
            sb.push_back(xq[i]);
            #1;
            x = sb.pop_front();
            checks++;
            if (obs1 !== {x.ctl1, x.st1, x.fl1}) begin
                errors++;
                $display("[TB] FAIL memwait[%0d] dut1 got=%h expected=%h", i, obs1, {x.ctl1, x.st1, x.fl1});
            end
            checks++;
            if (obs2 !== {x.ctl2, x.st2, x.fl2}) begin
                errors++;
                $display("[TB] FAIL memwait[%0d] dut2 got=%h expected=%h", i, obs2, {x.ctl2, x.st2, x.fl2});
            end
        end
    endtask

    task automatic test_halt();
        stim_t sq[$];
        exp_t  xq[$];
        stim_t s;
        stim_t idle;
        exp_t  x;
        applyReset();
        idle = '0;
        s = '0; s.halt = 1'b1;
        sq.push_back(s);    xq.push_back(mkx(JMP, 0, 0, JMP, 0, 0));
        sq.push_back(idle); xq.push_back(mkx(DRN, 0, 1, DRN, 0, 1));
        s = '0; s.br = 1'b1;
        sq.push_back(s);    xq.push_back(mkx(DRN, 0, 1, DRN, 0, 1));
        sq.push_back(idle); xq.push_back(mkx(DRN, 0, 1, DRN, 0, 1));
        s = '0; s.halt = 1'b1; s.br = 1'b1; s.busy = 1'b1;
        sq.push_back(s);    xq.push_back(mkx(HLT, 0, 1, HLT, 0, 1));
        s = '0; s.busy = 1'b1;
        sq.push_back(s);    xq.push_back(mkx(HLT, 0, 1, HLT, 0, 1));
        s = '0; s.rst = 1'b1;
        sq.push_back(s);    xq.push_back(mkx(NORM, 0, 1, NORM, 0, 1));
        sq.push_back(idle); xq.push_back(mkx(NORM, 0, 0, NORM, 0, 0));
        s = '0; s.halt = 1'b1;
        sq.push_back(s);    xq.push_back(mkx(JMP, 0, 0, JMP, 0, 0));
        sq.push_back(idle); xq.push_back(mkx(DRN, 0, 1, DRN, 0, 1));
        s = '0; s.busy = 1'b1;
        sq.push_back(s);    xq.push_back(mkx(FRZ, 0, 1, FRZ, 0, 1));
        sq.push_back(s);    xq.push_back(mkx(FRZ, 1, 1, FRZ, 1, 1));
        sq.push_back(idle); xq.push_back(mkx(DRN, 2, 1, DRN, 2, 1));
        sq.push_back(idle); xq.push_back(mkx(DRN, 2, 1, DRN, 2, 1));
        sq.push_back(idle); xq.push_back(mkx(HLT, 2, 1, HLT, 2, 1));
        s = '0; s.halt = 1'b1;
        sq.push_back(s);    xq.push_back(mkx(HLT, 2, 1, HLT, 2, 1));
        s = '0; s.rst = 1'b1;
        sq.push_back(s);    xq.push_back(mkx(NORM, 2, 1, NORM, 2, 1));
        s = '0; s.halt = 1'b1;
        sq.push_back(s);    xq.push_back(mkx(JMP, 0, 0, JMP, 0, 0));
        s = '0; s.rst = 1'b1;
        sq.push_back(s);    xq.push_back(mkx(NORM, 0, 1, NORM, 0, 1));
        sq.push_back(idle); xq.push_back(mkx(NORM, 0, 0, NORM, 0, 0));
        for (int i = 0; i < sq.size(); i++) begin
            @(negedge clk);
            applyStimulus(sq[i]);
            sb.push_back(xq[i]);
            #1;
            x = sb.pop_front();
            checks++;
            if (obs1 !== {x.ctl1, x.st1, x.fl1}) begin
                errors++;
                $display("[TB] FAIL halt[%0d] dut1 got=%h expected=%h", i, obs1, {x.ctl1, x.st1, x.fl1});
            end
            checks++;
            if (obs2 !== {x.ctl2, x.st2, x.fl2}) begin
                errors++;
                $display("[TB] FAIL halt[%0d] dut2 got=%h expected=%h", i, obs2, {x.ctl2, x.st2, x.fl2});
            end
        end
    endtask

    task automatic test_saturation();
        stim_t sq[$];
        exp_t  xq[$];
        stim_t s;
        exp_t  x;
        applyReset();
        s = '0; s.busy = 1'b1;
        for (int k = 0; k < 21; k++) begin
            sq.push_back(s);
            xq.push_back(mkx(FRZ, (k > 15) ? 15 : k, 0, FRZ, k, 0));
        end
        s = '0;
        sq.push_back(s); xq.push_back(mkx(NORM, 15, 0, NORM, 21, 0));
        for (int i = 0; i < sq.size(); i++) begin
            @(negedge clk);
            applyStimulus(sq[i]);
            sb.push_back(xq[i]);
            #1;
            x = sb.pop_front();
            checks++;
            if (obs1 !== {x.ctl1, x.st1, x.fl1}) begin
                errors++;
                $display("[TB] FAIL saturate[%0d] dut1 got=%h expected=%h", i, obs1, {x.ctl1, x.st1, x.fl1});
            end
            checks++;
            if (obs2 !== {x.ctl2, x.st2, x.fl2}) begin
                errors++;
                $display("[TB] FAIL saturate[%0d] dut2 got=%h expected=%h", i, obs2, {x.ctl2, x.st2, x.fl2});
            end
        end
    endtask

    initial begin
        stim_t s0;
        errors = 0;
        checks = 0;
        s0 = '0;
        s0.rst = 1'b1;
        applyStimulus(s0);
        repeat (2) @(posedge clk);
        test_reset();
        test_load_use();
        test_branch_priority();
        test_mem_wait();
        test_halt();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
